// File: rtl/kore_fetch_ctl.sv
// Instruction-fetch sequencer for the kore core: owns the PC, keeps at most one
// memory read in flight, and hands each fetched word to the opcode FSM.
module kore_fetch_ctl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             ir_valid,
  output logic [31:0]      ir_code,
  output logic [PC_W-1:0]  ir_pc,
  input  logic             ir_ready,
  input  logic             br_valid,
  input  logic [PC_W-1:0]  br_target,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FLUSH} state_t;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_t           state, state_nxt, resume;
  logic [PC_W-1:0]  pc, pc_nxt, ir_pc_nxt;
  logic [31:0]      ir_code_nxt;
  logic             ir_valid_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // halt is only honoured at the points where the sequencer would start a new fetch
  assign resume    = halt ? IDLE : REQ;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_valid_nxt = ir_valid;
    ir_code_nxt  = ir_code;
    ir_pc_nxt    = ir_pc;
    cnt_nxt      = fetch_cnt;
    case (state)
      IDLE: begin
        if (br_valid) pc_nxt = br_target;
        if (!halt)    state_nxt = REQ;
      end
      REQ: begin
        if (br_valid) pc_nxt = br_target;
        // a redirect coinciding with the grant leaves a stale response to drain
        if (imem_gnt) state_nxt = br_valid ? FLUSH : WAIT;
      end
      WAIT: begin
        if (br_valid) begin
          pc_nxt    = br_target;
          state_nxt = imem_rvalid ? resume : FLUSH;
        end else if (imem_rvalid) begin
          ir_code_nxt  = imem_rdata;
          ir_pc_nxt    = pc;
          pc_nxt       = pc + STEP;
          ir_valid_nxt = 1'b1;
          state_nxt    = HOLD;
        end
      end
      FLUSH: begin
        if (br_valid)    pc_nxt = br_target;
        if (imem_rvalid) state_nxt = resume;
      end
      HOLD: begin
        // a branch kills the held instruction, so it is not counted as handed off
        if (br_valid) begin
          ir_valid_nxt = 1'b0;
          pc_nxt       = br_target;
          state_nxt    = resume;
        end else if (ir_ready) begin
          ir_valid_nxt = 1'b0;
          cnt_nxt      = fetch_cnt + CNT_W'(1);
          state_nxt    = resume;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir_valid  <= 1'b0;
      ir_code   <= '0;
      ir_pc     <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir_valid  <= ir_valid_nxt;
      ir_code   <= ir_code_nxt;
      ir_pc     <= ir_pc_nxt;
      fetch_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_kore_fetch_ctl.sv
// Bench for kore_fetch_ctl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_kore_fetch_ctl;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic        ir_ready = 1'b0, br_valid = 1'b0;
  logic [31:0] imem_rdata = '0, br_target = '0;

  logic        imem_req, ir_valid, busy;
  logic [31:0] imem_addr, ir_code, ir_pc;
  logic [15:0] fetch_cnt;

  logic        w_req, w_irv, w_busy;
  logic [31:0] w_addr, w_code, w_irpc;
  logic [15:0] w_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  kore_fetch_ctl dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_code(ir_code), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .br_valid(br_valid), .br_target(br_target), .busy(busy), .fetch_cnt(fetch_cnt)
  );

  kore_fetch_ctl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(w_irv), .ir_code(w_code), .ir_pc(w_irpc), .ir_ready(ir_ready),
    .br_valid(br_valid), .br_target(br_target), .busy(w_busy), .fetch_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: a fetch engine that is either running or parked, may have one granted
  // read outstanding (possibly marked stale by a redirect), and may hold one IR word.
  typedef struct packed {
    logic        run;
    logic        out;
    logic        stale;
    logic        irv;
    logic [31:0] pc;
    logic [31:0] code;
    logic [31:0] irpc;
    logic [15:0] cnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t c);
    mdl_t n = c;
    if (!c.run) begin
      if (br_valid) n.pc = br_target;
      n.run = !halt;
    end else if (c.irv) begin
      if (br_valid || ir_ready) begin
        n.irv = 1'b0;
        n.run = !halt;
        if (br_valid) n.pc = br_target;
        else          n.cnt = c.cnt + 16'd1;
      end
    end else if (c.out) begin
      if (br_valid) n.pc = br_target;
      if (imem_rvalid) begin
        n.out = 1'b0;
        n.stale = 1'b0;
        if (c.stale || br_valid) n.run = !halt;
        else begin
          n.irv  = 1'b1;
          n.code = imem_rdata;
          n.irpc = c.pc;
          n.pc   = c.pc + 32'd4;
        end
      end else if (br_valid) n.stale = 1'b1;
    end else begin
      if (br_valid) n.pc = br_target;
      if (imem_gnt) begin
        n.out = 1'b1;
        n.stale = br_valid;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= mdl_step(m);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mdl_req",   imem_req,  m.run && !m.out && !m.irv);
      chk("mdl_addr",  imem_addr, m.pc);
      chk("mdl_busy",  busy,      m.run);
      chk("mdl_irv",   ir_valid,  m.irv);
      chk("mdl_code",  ir_code,   m.code);
      chk("mdl_irpc",  ir_pc,     m.irpc);
      chk("mdl_cnt",   fetch_cnt, m.cnt);
    end
  end

  // Well-behaved memory: grant always, answer one cycle after grant with addr^TAG.
  logic        auto_mem = 1'b1;
  logic        resp_due = 1'b0;
  logic [31:0] resp_addr = '0;

  always @(posedge clk) begin
    resp_due <= imem_req && imem_gnt;
    if (imem_req && imem_gnt) resp_addr <= imem_addr;
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    if (auto_mem) begin
      imem_gnt    = 1'b1;
      imem_rvalid = resp_due;
      imem_rdata  = resp_addr ^ TAG;
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    halt = 1'b0; imem_gnt = 1'b1; ir_ready = 1'b1; br_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_cnt", fetch_cnt, 0);

    // sequential fetch, one instruction per 3 cycles
    for (int k = 0; k < 4; k++) begin
      goto(1 + 3 * k);
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      if (k == 0) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (k == 1) chk("wrap_addr1", w_addr, 32'h0000_0000);
      goto(2 + 3 * k);
      chk("seq_irv_lo", ir_valid, 0);
      goto(3 + 3 * k);
      chk("seq_irv_hi", ir_valid, 1);
      chk("seq_code", ir_code, 32'(4 * k) ^ TAG);
      chk("seq_irpc", ir_pc, 32'(4 * k));
    end
    goto(13);
    chk("seq_cnt4", fetch_cnt, 4);
    ir_ready = 1'b0;

    // backpressure in HOLD
    for (int c = 15; c <= 19; c++) begin
      goto(c);
      chk("bp_irv", ir_valid, 1);
      chk("bp_code", ir_code, 32'h10 ^ TAG);
      chk("bp_irpc", ir_pc, 32'h10);
      chk("bp_req", imem_req, 0);
    end
    ir_ready = 1'b1;
    goto(20);
    chk("bp_irv_fall", ir_valid, 0);
    chk("bp_cnt5", fetch_cnt, 5);
    ir_ready = 1'b0;
    goto(21);
    chk("bp_single", fetch_cnt, 5);

    // redirect in HOLD together with ir_ready
    goto(22);
    chk("hbr_irv", ir_valid, 1);
    br_valid = 1'b1; br_target = 32'h100; ir_ready = 1'b1;
    goto(23);
    br_valid = 1'b0;
    chk("hbr_irv_lo", ir_valid, 0);
    chk("hbr_cnt", fetch_cnt, 5);
    chk("hbr_req", imem_req, 1);
    chk("hbr_addr", imem_addr, 32'h100);
    goto(25);
    chk("hbr_code", ir_code, 32'h100 ^ TAG);

    // redirect in WAIT, stale response three cycles later
    goto(26);
    chk("wbr_req", imem_req, 1);
    auto_mem = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    goto(27);
    br_valid = 1'b1; br_target = 32'h40; imem_gnt = 1'b0;
    goto(28);
    br_valid = 1'b0;
    chk("wbr_req28", imem_req, 0);
    goto(29);
    chk("wbr_req29", imem_req, 0);
    goto(30);
    chk("wbr_req30", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    goto(31);
    imem_rvalid = 1'b0;
    chk("wbr_irv", ir_valid, 0);
    chk("wbr_req31", imem_req, 1);
    chk("wbr_addr", imem_addr, 32'h40);
    imem_gnt = 1'b1;
    // redirect and response in the same cycle
    goto(32);
    chk("sbr_req32", imem_req, 0);
    br_valid = 1'b1; br_target = 32'h40; imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678; imem_gnt = 1'b0;
    goto(33);
    br_valid = 1'b0; imem_rvalid = 1'b0;
    chk("sbr_irv", ir_valid, 0);
    chk("sbr_req", imem_req, 1);
    chk("sbr_addr", imem_addr, 32'h40);
    auto_mem = 1'b1; imem_gnt = 1'b1;
    goto(35);
    chk("sbr_code", ir_code, 32'h40 ^ TAG);

    // halt during WAIT
    goto(37);
    chk("halt_wait", busy, 1);
    halt = 1'b1;
    goto(38);
    chk("halt_irv", ir_valid, 1);
    chk("halt_code", ir_code, 32'h44 ^ TAG);
    goto(39);
    chk("halt_busy", busy, 0);
    chk("halt_req", imem_req, 0);
    goto(42);
    chk("halt_busy42", busy, 0);
    chk("halt_req42", imem_req, 0);
    halt = 1'b0;
    goto(43);
    chk("resume_addr", imem_addr, 32'h48);

    // asynchronous reset in WAIT
    goto(44);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_irv", ir_valid, 0);
    chk("arst_code", ir_code, 0);
    chk("arst_irpc", ir_pc, 0);
    chk("arst_cnt", fetch_cnt, 0);
    repeat (2) step();
    rst_n = 1'b1;
    cyc = 0;
    goto(1);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);

    // randomized traffic, including responses outside WAIT/FLUSH
    auto_mem = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      imem_gnt    = ($urandom_range(0, 1) == 1);
      imem_rvalid = ($urandom_range(0, 9) < 4);
      imem_rdata  = $urandom();
      ir_ready    = ($urandom_range(0, 1) == 1);
      halt        = ($urandom_range(0, 19) == 0);
      br_valid    = ($urandom_range(0, 11) == 0);
      br_target   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 2)) * 32'd4
                                                : $urandom();
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kore_fetch_ctl.md
# kore_fetch_ctl

Instruction-fetch sequencer for the kore core. Owns the program counter, issues single-outstanding reads to instruction memory, and captures each returned word into the instruction register. It presents the word to the kore opcode FSM through a valid/ready handshake and accepts branch redirects (taken-branch target) back from it. It also counts instructions handed off.

## Interface
- PC_W, 32, program counter and memory address width
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- PC_STEP, 4, PC increment per sequential fetch
- CNT_W, 16, width of handed-off instruction counter

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- halt  in  1  stop issuing new fetches
- imem_req  out  1  fetch request, held until granted
- imem_addr  out  PC_W  fetch address (= pc)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- ir_valid  out  1  IR holds an instruction for the opcode FSM
- ir_code  out  32  registered instruction word
- ir_pc  out  PC_W  address of ir_code
- ir_ready  in  1  opcode FSM consumes IR
- br_valid  in  1  redirect request, one-cycle pulse
- br_target  in  PC_W  redirect address
- busy  out  1  state != IDLE
- fetch_cnt  out  CNT_W  instructions handed off, wraps

## Operation
- Reset (asynchronous): state IDLE, pc=RESET_PC, ir_valid=0, ir_code=0, ir_pc=0, fetch_cnt=0. imem_req=0, busy=0.
- States: IDLE, REQ, WAIT, HOLD, FLUSH. Only one outstanding memory request at any time.
- IDLE: halt=0 -> REQ. br_valid -> pc<=br_target; stay IDLE if halt=1.
- REQ: imem_req=1, imem_addr=pc. imem_gnt -> WAIT. br_valid (no gnt) -> pc<=br_target, stay REQ. Address may change before grant only via redirect. br_valid with imem_gnt -> pc<=br_target, go FLUSH.
- WAIT: imem_rvalid and no br_valid -> ir_code<=imem_rdata, ir_pc<=pc, pc<=pc+PC_STEP, ir_valid<=1, go HOLD. br_valid without rvalid -> pc<=br_target, go FLUSH. br_valid with rvalid -> data discarded, pc<=br_target, go REQ (IDLE if halt).
- FLUSH: wait for the stale response. imem_rvalid -> discard, go REQ (IDLE if halt). Further br_valid overwrites pc.
- HOLD: ir_valid=1, ir_code/ir_pc stable. ir_ready and no br_valid -> ir_valid<=0, fetch_cnt+1, go REQ (IDLE if halt). br_valid (with or without ir_ready) -> ir_valid<=0, pc<=br_target, fetch_cnt unchanged, go REQ (IDLE if halt). The branch wins.
- halt is sampled only in IDLE and on leaving HOLD/FLUSH/WAIT. An in-flight request always completes.
- pc arithmetic is modulo 2^PC_W: pc+PC_STEP wraps silently. fetch_cnt wraps modulo 2^CNT_W.
- imem_rvalid outside WAIT/FLUSH is ignored.

## Timing
- All outputs registered except imem_req, imem_addr and busy, which decode from state/pc.
- With imem_gnt tied 1 and rvalid one cycle after grant:
  - Cycle 0: IDLE.
  - Cycle 1: REQ, grant.
  - Cycle 2: WAIT, rvalid.
  - Cycle 3: ir_valid=1.
  - Steady-state throughput is one instruction per 3 cycles when ir_ready=1 in HOLD.
- A redirect takes effect as the next imem_addr at most 1 cycle after its pulse when in REQ/IDLE. In WAIT it takes effect after the stale response is drained.
- ir_valid falls in the cycle after the ir_ready or br_valid handshake.

## Test plan
- Reset/sequential: release rst_n, halt=0, gnt=1, rvalid 1 cycle after gnt, ir_ready=1, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8,C, ir_code matches, fetch_cnt=4 after 4 handoffs, first ir_valid at cycle 3.
- Backpressure: ir_ready=0 for 5 cycles in HOLD -> ir_valid, ir_code, ir_pc stable, no imem_req. Raise ir_ready -> single handoff, fetch_cnt+1.
- Redirect in HOLD with ir_ready same cycle (br_target=0x100) -> no count increment, next imem_addr=0x100, ir_valid low next cycle.
- Redirect in WAIT (br_target=0x40), rvalid 3 cycles later -> response discarded, ir_valid stays 0, next request addr 0x40. Repeat with br_valid and rvalid in the same cycle -> same result with no FLUSH visit.
- Wrap and halt: RESET_PC=32'hFFFF_FFFC -> second fetch addr 0x0. Assert halt during WAIT -> IR delivered, then IDLE, busy=0, no further imem_req.
- Async reset mid-WAIT -> all outputs return to reset values immediately. Fetch restarts at RESET_PC.
